spi_ram: RTL

//  Single-port command-driven RAM sitting directly downstream of the SPI slave.

---
 rtl/spi_ram_pkg.sv | 22 ++
 rtl/spi_ram_if.sv | 17 +
 rtl/spi_ram_array.sv | 23 ++
 rtl/spi_ram.sv | 55 +++++
 4 files changed

// File: rtl/spi_ram_pkg.sv
// spi_ram_pkg: shared command encoding, widths and word encoding for the SPI RAM.
// SPI_RAM_PARITY_EN widens each stored word with an even-parity bit.
package spi_ram_pkg;
  localparam int CMD_W = 2;
  localparam int DATA_W = 8;
  localparam int DIN_W = CMD_W + DATA_W;
  localparam int ADDR_SIZE = 8;
  localparam int MEM_DEPTH = 2 ** ADDR_SIZE;
`ifdef SPI_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  typedef enum logic [CMD_W-1:0] {WR_ADDR, WR_DATA, RD_ADDR, RD_DATA} cmd_e;
  function automatic logic [WORD_W-1:0] encode_word(input logic [DATA_W-1:0] d);
`ifdef SPI_RAM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction
endpackage

// File: rtl/spi_ram_if.sv
// spi_ram_if: command/response bundle between the SPI slave (master side) and the RAM.
// par_err is present only when SPI_RAM_PARITY_EN is defined.
interface spi_ram_if;
  import spi_ram_pkg::*;
  logic [DIN_W-1:0] din;
  logic rx_valid;
  logic [DATA_W-1:0] dout;
  logic tx_valid;
`ifdef SPI_RAM_PARITY_EN
  logic par_err;
  modport master (output din, rx_valid, input dout, tx_valid, par_err);
  modport slave (input din, rx_valid, output dout, tx_valid, par_err);
`else
  modport master (output din, rx_valid, input dout, tx_valid);
  modport slave (input din, rx_valid, output dout, tx_valid);
`endif
endinterface

// File: rtl/spi_ram_array.sv
// spi_ram_array: storage with synchronous write and an enabled, registered read port.
// Contents are never reset; only the read register is.
module spi_ram_array
  import spi_ram_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we_i,
  input  logic [ADDR_SIZE-1:0] waddr_i,
  input  logic [WORD_W-1:0]    wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_SIZE-1:0] raddr_i,
  output logic [WORD_W-1:0]    rdata_o
);
  logic [WORD_W-1:0] mem_q [MEM_DEPTH];
  logic [WORD_W-1:0] rdata_q;
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  assign rdata_o = rdata_q;
endmodule

// File: rtl/spi_ram.sv
// spi_ram: command-driven RAM behind the SPI slave; edge-detects rx_valid, decodes commands.
// SPI_RAM_PARITY_EN adds parity storage and the par_err output.
module spi_ram
  import spi_ram_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  spi_ram_if.slave   bus
);
  logic rx_valid_q, tx_valid_q, tx_valid_d, accept, we, re;
  logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic [WORD_W-1:0] rdata;
  cmd_e cmd;
  always_comb begin
    cmd = cmd_e'(bus.din[DIN_W-1:DATA_W]);
    accept = bus.rx_valid && !rx_valid_q;
    we = accept && cmd == WR_DATA;
    re = accept && cmd == RD_DATA;
    wr_addr_d = !accept ? wr_addr_q :
                cmd == WR_ADDR ? bus.din[ADDR_SIZE-1:0] :
                cmd == WR_DATA ? wr_addr_q + ADDR_SIZE'(1) : wr_addr_q;
    rd_addr_d = !accept ? rd_addr_q :
                cmd == RD_ADDR ? bus.din[ADDR_SIZE-1:0] :
                cmd == RD_DATA ? rd_addr_q + ADDR_SIZE'(1) : rd_addr_q;
    tx_valid_d = accept ? cmd == RD_DATA : tx_valid_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rx_valid_q <= 1'b0;
      tx_valid_q <= 1'b0;
      wr_addr_q <= '0;
      rd_addr_q <= '0;
    end else begin
      rx_valid_q <= bus.rx_valid;
      tx_valid_q <= tx_valid_d;
      wr_addr_q <= wr_addr_d;
      rd_addr_q <= rd_addr_d;
    end
  spi_ram_array u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (we),
    .waddr_i (wr_addr_q),
    .wdata_i (encode_word(bus.din[DATA_W-1:0])),
    .re_i    (re),
    .raddr_i (rd_addr_q),
    .rdata_o (rdata)
  );
  assign bus.dout = rdata[DATA_W-1:0];
  assign bus.tx_valid = tx_valid_q;
`ifdef SPI_RAM_PARITY_EN
  // Read register only changes on RD_DATA, so the error follows tx_valid's hold/clear.
  assign bus.par_err = tx_valid_q && (rdata[DATA_W] != ^rdata[DATA_W-1:0]);
`endif
endmodule
